dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port data memory between the core and a host loader.
// The core wins by default; the host gets starvation relief and can hold the memory for a bounded locked burst.
//
// state  | meaning
// -------+--------------------------------------------------------------
// CORE   | no locked burst active; core wins unless the host is starved or the core is idle
// HOST   | host holds a locked burst; it keeps the grant until it drops the lock or lock_cnt reaches the cap
module dmem_arbiter (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CoreReq,
    input  logic       CoreWe,
    input  logic [7:0] CoreAddr,
    input  logic [7:0] CoreWData,
    output logic       CoreStall,
    output logic [7:0] CoreRData,
    input  logic       HostReq,
    input  logic       HostWe,
    input  logic       HostLock,
    input  logic [7:0] HostAddr,
    input  logic [7:0] HostWData,
    output logic       HostGnt,
    output logic       HostRValid,
    output logic [7:0] HostRData,
    output logic       MemWriteEn,
    output logic [7:0] MemAddr,
    output logic [7:0] MemWData,
    input  logic [7:0] MemRData
);

    typedef enum logic {
        ST_CORE = 1'b0,
        ST_HOST = 1'b1
    } state_t;

    localparam logic [1:0] WAIT_MAX = 2'd3;
    localparam logic [3:0] LOCK_MAX = 4'd8;

    state_t     state;
    logic [1:0] wait_cnt;
    logic [3:0] lock_cnt;
    logic       host_gnt;
    logic       core_gnt;
    logic       host_rd;

    always_comb begin
        host_gnt = HostReq && (!CoreReq || (wait_cnt == WAIT_MAX) ||
                   ((state == ST_HOST) && HostLock && (lock_cnt < LOCK_MAX)));
        core_gnt = CoreReq && !host_gnt;
        host_rd  = host_gnt && !HostWe;
    end

    always_comb begin
        MemWriteEn = 1'b0;
        MemAddr    = 8'h00;
        MemWData   = 8'h00;
        if (host_gnt) begin
            MemWriteEn = HostWe;
            MemAddr    = HostAddr;
            MemWData   = HostWData;
        end else if (core_gnt) begin
            MemWriteEn = CoreWe;
            MemAddr    = CoreAddr;
            MemWData   = CoreWData;
        end
    end

    assign CoreStall = CoreReq && host_gnt;
    assign HostGnt   = host_gnt;
    assign CoreRData = MemRData;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_CORE;
            wait_cnt   <= 2'd0;
            lock_cnt   <= 4'd0;
            HostRValid <= 1'b0;
            HostRData  <= 8'h00;
        end else begin
            // Starvation counter only runs while the host is actually being refused.
            if (HostReq && !host_gnt) begin
                wait_cnt <= (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 2'd1;
            end else begin
                wait_cnt <= 2'd0;
            end

            // The grant that opens a burst counts as its first beat.
            case (state)
                ST_CORE: begin
                    if (host_gnt && HostLock) begin
                        state    <= ST_HOST;
                        lock_cnt <= 4'd1;
                    end else begin
                        lock_cnt <= 4'd0;
                    end
                end
                ST_HOST: begin
                    if (host_gnt && HostLock) begin
                        lock_cnt <= (lock_cnt == LOCK_MAX) ? LOCK_MAX : lock_cnt + 4'd1;
                    end else begin
                        state    <= ST_CORE;
                        lock_cnt <= 4'd0;
                    end
                end
                default: begin
                    state    <= ST_CORE;
                    lock_cnt <= 4'd0;
                end
            endcase

            HostRValid <= host_rd;
            if (host_rd) begin
                HostRData <= MemRData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       CoreReq = 1'b0, CoreWe = 1'b0;
    logic [7:0] CoreAddr = 8'h00, CoreWData = 8'h00;
    logic       CoreStall;
    logic [7:0] CoreRData;
    logic       HostReq = 1'b0, HostWe = 1'b0, HostLock = 1'b0;
    logic [7:0] HostAddr = 8'h00, HostWData = 8'h00;
    logic       HostGnt, HostRValid;
    logic [7:0] HostRData;
    logic       MemWriteEn;
    logic [7:0] MemAddr, MemWData, MemRData;

    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: plain counts of consecutive refused host cycles and locked burst beats.
    int         m_waits = 0;
    int         m_burst = 0;
    logic       m_rvalid = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_known = 1'b0;

    logic       obs_hgnt, obs_stall, obs_wen, obs_rvalid;
    logic [7:0] obs_addr, obs_wd, obs_crdata, obs_rdata;

    always #5 Clk = ~Clk;

    assign MemRData = env_mem[MemAddr];

    dmem_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CoreReq   (CoreReq),
        .CoreWe    (CoreWe),
        .CoreAddr  (CoreAddr),
        .CoreWData (CoreWData),
        .CoreStall (CoreStall),
        .CoreRData (CoreRData),
        .HostReq   (HostReq),
        .HostWe    (HostWe),
        .HostLock  (HostLock),
        .HostAddr  (HostAddr),
        .HostWData (HostWData),
        .HostGnt   (HostGnt),
        .HostRValid(HostRValid),
        .HostRData (HostRData),
        .MemWriteEn(MemWriteEn),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_cycle(input logic rst, input logic creq, input logic cwe,
                            input logic [7:0] caddr, input logic [7:0] cwd,
                            input logic hreq, input logic hwe, input logic hlock,
                            input logic [7:0] haddr, input logic [7:0] hwd);
        logic       hg, cg, e_wen;
        logic [7:0] e_addr, e_wd;
        if (rst) begin
            cwe = 1'b0;
            hwe = 1'b0;
        end
        @(negedge Clk);
        Reset = rst; CoreReq = creq; CoreWe = cwe; CoreAddr = caddr; CoreWData = cwd;
        HostReq = hreq; HostWe = hwe; HostLock = hlock; HostAddr = haddr; HostWData = hwd;

        hg = hreq && (!creq || (m_waits >= 3) || ((m_burst > 0) && (m_burst < 8) && hlock));
        cg = creq && !hg;
        e_wen = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
        if (hg) begin
            e_wen = hwe; e_addr = haddr; e_wd = hwd;
        end else if (cg) begin
            e_wen = cwe; e_addr = caddr; e_wd = cwd;
        end

        #1;
        obs_hgnt = HostGnt; obs_stall = CoreStall; obs_wen = MemWriteEn;
        obs_addr = MemAddr; obs_wd = MemWData; obs_crdata = CoreRData;
        obs_rvalid = HostRValid; obs_rdata = HostRData;

        if (m_known) begin
            chk("host_rvalid", {15'd0, obs_rvalid}, {15'd0, m_rvalid});
            chk("host_rdata", {8'd0, obs_rdata}, {8'd0, m_rdata});
            if (!rst) begin
                chk("host_gnt", {15'd0, obs_hgnt}, {15'd0, hg});
                chk("core_stall", {15'd0, obs_stall}, {15'd0, creq && hg});
                chk("mem_we", {15'd0, obs_wen}, {15'd0, e_wen});
                chk("mem_addr", {8'd0, obs_addr}, {8'd0, e_addr});
                chk("mem_wdata", {8'd0, obs_wd}, {8'd0, e_wd});
                chk("core_rdata", {8'd0, obs_crdata}, {8'd0, ref_mem[e_addr]});
            end
        end

        @(posedge Clk);
        if (obs_wen === 1'b1) env_mem[obs_addr] = obs_wd;
        if (rst) begin
            m_waits = 0; m_burst = 0; m_rvalid = 1'b0; m_rdata = 8'h00; m_known = 1'b1;
        end else if (m_known) begin
            m_waits  = (hreq && !hg) ? m_waits + 1 : 0;
            m_burst  = (hg && hlock) ? m_burst + 1 : 0;
            m_rvalid = hg && !hwe;
            if (m_rvalid) m_rdata = ref_mem[haddr];
            if (e_wen) ref_mem[e_addr] = e_wd;
        end
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0]  pat8;
        logic [11:0] pat12;
        logic        r_creq, r_cwe, r_hreq, r_hwe, r_hlock, r_rst;

        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end

        do_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        do_cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);

        idle();
        chk("d_idle_we", {15'd0, obs_wen}, 16'd0);
        chk("d_idle_addr", {8'd0, obs_addr}, 16'd0);
        chk("d_idle_gnt", {15'd0, obs_hgnt}, 16'd0);
        chk("d_idle_stall", {15'd0, obs_stall}, 16'd0);

        do_cycle(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("d_cw_we", {15'd0, obs_wen}, 16'd1);
        chk("d_cw_stall", {15'd0, obs_stall}, 16'd0);
        do_cycle(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("d_cr_data", {8'd0, obs_crdata}, 16'h00A5);
        chk("d_cr_stall", {15'd0, obs_stall}, 16'd0);

        do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h20, 8'h3C);
        chk("d_hw_gnt", {15'd0, obs_hgnt}, 16'd1);
        do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        chk("d_hr_gnt", {15'd0, obs_hgnt}, 16'd1);
        idle();
        chk("d_hr_valid", {15'd0, obs_rvalid}, 16'd1);
        chk("d_hr_data", {8'd0, obs_rdata}, 16'h003C);

        // Both requesting, no lock: host wins one slot in four.
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
            pat8[i] = obs_hgnt;
        end
        chk("d_fair_pattern", {8'd0, pat8}, 16'h0088);

        // Locked burst against a busy core: 8 host beats starting once the host is starved.
        idle();
        for (int i = 0; i < 12; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 1'b1, 8'h21, 8'h00);
            pat12[i] = obs_hgnt;
        end
        chk("d_burst_pattern", {4'd0, pat12}, 16'h07F8);

        // Reset on beat 4 of a locked read burst.
        idle();
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'(8'h30 + i), 8'h00);
        end
        do_cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h34, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0, 1'b1, 8'h35, 8'h00);
        chk("d_rst_gnt", {15'd0, obs_hgnt}, 16'd0);
        chk("d_rst_valid", {15'd0, obs_rvalid}, 16'd0);

        // Long uncontested burst: beat count must saturate, not wrap.
        idle();
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 8'(i));
        end
        do_cycle(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 1'b1, 8'h60, 8'h77);
        chk("d_sat_gnt", {15'd0, obs_hgnt}, 16'd0);
        idle();

        r_creq = 1'b0; r_hreq = 1'b0; r_hlock = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_creq = ($urandom_range(99) < 70);
            if ($urandom_range(3) == 0) r_hreq = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) r_hlock = ~r_hlock;
            r_cwe = 1'($urandom_range(1));
            r_hwe = 1'($urandom_range(1));
            r_rst = ($urandom_range(99) == 0);
            do_cycle(r_rst, r_creq, r_cwe, 8'($urandom_range(15)), 8'($urandom),
                     r_hreq, r_hwe, r_hlock, 8'($urandom_range(15)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
